halt_dump_engine: RTL

Synthesizable post-halt state dump unit sitting beside `Top`, between the CPU halt flag (`Hcf`), the unified byte memory, the register file and a debug output stream. On halt it walks a parametrised table of memory regions in fixed-width beats, then the register file, and emits every beat over a valid/ready stream. Software-visible test results (sort, fib, conv2d, instr_test, stack) can then be checked on silicon or FPGA without simulator hierarchy access.

---
 rtl/dump_pkg.sv | 12 +
 rtl/dump_beat_buf.sv | 33 +++
 rtl/halt_dump_engine.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// dump_pkg: shared types and helpers for the post-halt state dump engine
package dump_pkg;
    typedef enum logic [2:0] {IDLE, MEM_FILL, MEM_OUT, REG_FILL, REG_OUT, DONE} state_t;
    localparam logic KIND_MEM = 1'b0;
    localparam logic KIND_REG = 1'b1;
    function automatic int rpb(input int beat_bytes, input int reg_w);
        return beat_bytes * 8 / reg_w;
    endfunction
    function automatic int beat_off_w(input int beat_bytes);
        return $clog2(beat_bytes);
    endfunction
endpackage

// File: rtl/dump_beat_buf.sv
// dump_beat_buf: beat assembly register with per-byte strobes, byte or register lanes
module dump_beat_buf
    import dump_pkg::*;
#(
    parameter int BEAT_BYTES = 16,
    parameter int REG_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          we,
    input  logic                          kind,
    input  logic [beat_off_w(BEAT_BYTES)-1:0] lane,
    input  logic [REG_W-1:0]              wdata,
    output logic [BEAT_BYTES*8-1:0]       data,
    output logic [BEAT_BYTES-1:0]         strb
);
    localparam int RB = REG_W / 8;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
            strb <= '0;
        end else if (we) begin
            if (kind == KIND_REG) begin
                data[lane*REG_W +: REG_W] <= wdata;
                strb[lane*RB +: RB]       <= '1;
            end else begin
                data[lane*8 +: 8] <= wdata[7:0];
                strb[lane]        <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/halt_dump_engine.sv
// halt_dump_engine: on CPU halt, streams enabled memory regions then the register file as beats
module halt_dump_engine
    import dump_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int BEAT_BYTES  = 16,
    parameter int NUM_REGIONS = 6,
    parameter int REG_COUNT   = 32,
    parameter int REG_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hcf,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_last,
    input  logic [NUM_REGIONS-1:0]        region_en,
    output logic                          mem_re,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [7:0]                    mem_rdata,
    output logic                          rf_re,
    output logic [$clog2(REG_COUNT)-1:0]  rf_addr,
    input  logic [REG_W-1:0]              rf_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BEAT_BYTES*8-1:0]       out_data,
    output logic [ADDR_W-1:0]             out_addr,
    output logic                          out_kind,
    output logic [BEAT_BYTES-1:0]         out_strb,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);
    localparam int RPB  = rpb(BEAT_BYTES, REG_W);
    localparam int OB   = beat_off_w(BEAT_BYTES);
    localparam int CW   = OB + 1;
    localparam int RA_W = $clog2(REG_COUNT);
    localparam int RW   = $clog2(REG_COUNT + RPB) + 1;
    localparam int RI_W = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;

    state_t state, state_n;
    logic [NUM_REGIONS*ADDR_W-1:0] base_q, last_q;
    logic [NUM_REGIONS-1:0] en_q;
    logic [RI_W-1:0] cur, nidx;
    logic found, acc, beat_more, reg_more, fill, clr, cap_v;
    logic [ADDR_W-1:0] ptr, byte_addr, cur_base, cur_last, nbase;
    logic [ADDR_W:0] nxt;
    logic [CW-1:0] cnt;
    logic [OB-1:0] cap_lane;
    logic [RW-1:0] r, ridx;

    // In IDLE the live table is searched from the bottom; later, only entries above cur
    always_comb begin
        found = 1'b0;
        nidx  = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if ((state == IDLE) ? region_en[k] : (en_q[k] && k > int'(cur))) begin
                found = 1'b1;
                nidx  = RI_W'(k);
            end
        end
    end

    assign nbase     = (state == IDLE) ? region_base[nidx*ADDR_W +: ADDR_W] : base_q[nidx*ADDR_W +: ADDR_W];
    assign cur_base  = base_q[cur*ADDR_W +: ADDR_W];
    assign cur_last  = last_q[cur*ADDR_W +: ADDR_W];
    assign byte_addr = ptr + ADDR_W'(cnt);
    assign nxt       = {1'b0, ptr} + (ADDR_W+1)'(BEAT_BYTES);
    assign beat_more = !nxt[ADDR_W] && nxt[ADDR_W-1:0] <= cur_last;
    assign ridx      = r + RW'(cnt);
    assign reg_more  = (r + RW'(RPB)) < RW'(REG_COUNT);
    assign acc       = out_valid && out_ready;
    assign fill      = state == MEM_FILL || state == REG_FILL;
    assign clr       = (state_n == MEM_FILL || state_n == REG_FILL) && state_n != state;

    assign mem_re    = state == MEM_FILL && cnt < CW'(BEAT_BYTES) && byte_addr >= cur_base && byte_addr <= cur_last;
    assign mem_addr  = mem_re ? byte_addr : '0;
    assign rf_re     = state == REG_FILL && cnt < CW'(RPB) && ridx < RW'(REG_COUNT);
    assign rf_addr   = rf_re ? ridx[RA_W-1:0] : '0;
    assign out_valid = state == MEM_OUT || state == REG_OUT;
    assign out_kind  = (state == REG_OUT) ? KIND_REG : KIND_MEM;
    assign out_addr  = (state == MEM_OUT) ? ptr : (state == REG_OUT) ? ADDR_W'(r) : '0;
    assign out_last  = state == REG_OUT && !reg_more;
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = hcf ? (found ? MEM_FILL : REG_FILL) : IDLE;
            MEM_FILL: state_n = (cnt == CW'(BEAT_BYTES)) ? MEM_OUT : MEM_FILL;
            MEM_OUT:  state_n = acc ? ((beat_more || found) ? MEM_FILL : REG_FILL) : MEM_OUT;
            REG_FILL: state_n = (cnt == CW'(RPB)) ? REG_OUT : REG_FILL;
            REG_OUT:  state_n = acc ? (reg_more ? REG_FILL : DONE) : REG_OUT;
            DONE:     state_n = hcf ? DONE : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Read data lands one cycle after the strobe, so the lane is captured alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            last_q   <= '0;
            en_q     <= '0;
            cur      <= '0;
            ptr      <= '0;
            r        <= '0;
            cnt      <= '0;
            cap_v    <= 1'b0;
            cap_lane <= '0;
        end else begin
            cap_v    <= mem_re || rf_re;
            cap_lane <= cnt[OB-1:0];
            cnt      <= (fill && state_n == state) ? cnt + 1'b1 : '0;
            if (state == IDLE && hcf) begin
                base_q <= region_base;
                last_q <= region_last;
                en_q   <= region_en;
                r      <= '0;
                cur    <= nidx;
                ptr    <= {nbase[ADDR_W-1:OB], {OB{1'b0}}};
            end
            if (state == MEM_OUT && acc) begin
                if (beat_more) begin
                    ptr <= nxt[ADDR_W-1:0];
                end else begin
                    cur <= nidx;
                    ptr <= {nbase[ADDR_W-1:OB], {OB{1'b0}}};
                end
            end
            if (state == REG_OUT && acc && reg_more) r <= r + RW'(RPB);
        end
    end

    dump_beat_buf #(.BEAT_BYTES(BEAT_BYTES), .REG_W(REG_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we    (cap_v),
        .kind  ((state == REG_FILL) ? KIND_REG : KIND_MEM),
        .lane  (cap_lane),
        .wdata ((state == REG_FILL) ? rf_rdata : REG_W'(mem_rdata)),
        .data  (out_data),
        .strb  (out_strb)
    );
endmodule
